// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state encoding,
// one-hot grant encodings and the state-to-grant decode.
package wb_arb_pkg;

    // State values are chosen so that the grant one-hot equals the state code
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    function automatic logic [1:0] state_to_gnt(input arb_state_t s);
        case (s)
            ST_GNT0: return GNT_M0;
            ST_GNT1: return GNT_M1;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Round-robin pick between two requesters: a lone requester wins, on contention
// the requester that did not win last time is picked. Result is one-hot.
module wb_arb_rr_pick
    import wb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    // Select the winner from the request vector and the last-winner flag
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pick = GNT_NONE;
        case (req)
            2'b01:   pick = GNT_M0;
            2'b10:   pick = GNT_M1;
            2'b11:   pick = last ? GNT_M0 : GNT_M1;
            default: pick = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the address decoder.
// Master 0 is the SPI-slave bridge, master 1 the on-FPGA sequencer/soft core.
// The granted master owns the bus for its whole cyc; one idle cycle separates grants.
// Optional stall watchdog: define WB_ARB_TIMEOUT_EN.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    input  logic              m0_we_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    input  logic              m1_we_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    output logic              s_we_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic              s_ack_i,
    output logic [1:0]        gnt_o
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_master_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end

    arb_state_t state, state_d;
    logic       last, last_d;   // index of the master granted most recently
    logic [1:0] pick;
    logic       timeout;

    wb_arb_rr_pick u_pick (
        .req  ({m1_cyc_i, m0_cyc_i}),
        .last (last),
        .pick (pick)
    );

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] stall_cnt;

    // Count consecutive stalled strobe cycles of the granted master
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   stall_cnt <= '0;
        else if (s_stb_o && !s_ack_i) stall_cnt <= stall_cnt + 16'd1;
        else                          stall_cnt <= '0;
    end

    // s_stb_o is forced low in the timeout cycle, which also clears the counter
    assign timeout = (state != ST_IDLE) && (stall_cnt == TIMEOUT_LIMIT);
`else
    assign timeout = 1'b0;
`endif

    // State and last-winner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state <= state_d;
            last  <= last_d;
        end
    end

    assign gnt_o = state_to_gnt(state);

    // Next-state decision and bus/master muxing from the current grant
    always_comb begin
        state_d  = state;
        last_d   = last;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick == GNT_M0) begin
                    state_d = ST_GNT0;
                    last_d  = 1'b0;
                end else if (pick == GNT_M1) begin
                    state_d = ST_GNT1;
                    last_d  = 1'b1;
                end
            end
            ST_GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i & ~timeout;
                s_stb_o  = m0_stb_i & ~timeout;
                m0_ack_o = s_ack_i & m0_stb_i & ~timeout;
                m0_dat_o = s_dat_i;
                m0_err_o = timeout;
                if (timeout) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                end else if (!m0_cyc_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i & ~timeout;
                s_stb_o  = m1_stb_i & ~timeout;
                m1_ack_o = s_ack_i & m1_stb_i & ~timeout;
                m1_dat_o = s_dat_i;
                m1_err_o = timeout;
                if (timeout) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b1;
                end else if (!m1_cyc_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Two-master round-robin arbiter in front of the Wishbone address decoder.
- Master 0 is the SPI-slave bridge (host/ESP32 side); master 1 is the on-FPGA sequencer or soft-core port.
- The winning master owns the shared 8-bit bus for its whole cycle (cyc high). Its strobe, data and ack are muxed to and from the decoder; the losing master sees no ack.
- Optional watchdog terminates stalled cycles with an error pulse.

Parameters:
- ADDR_W, 8, address width of masters and bus
- DATA_W, 8, data width
- TIMEOUT_CYCLES, 255, stall cycles before error; valid range 2..65535

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_adr_i  in  ADDR_W  master 0 address
- m0_dat_i  in  DATA_W  master 0 write data
- m0_dat_o  out  DATA_W  master 0 read data
- m0_we_i  in  1  master 0 write enable
- m0_cyc_i  in  1  master 0 cycle/request
- m0_stb_i  in  1  master 0 strobe
- m0_ack_o  out  1  master 0 acknowledge
- m0_err_o  out  1  master 0 timeout error
- m1_*  same set as m0_*  master 1
- s_adr_o  out  ADDR_W  to decoder address
- s_dat_o  out  DATA_W  to decoder write data
- s_dat_i  in  DATA_W  from decoder read data
- s_we_o  out  1  to decoder write enable
- s_cyc_o  out  1  to decoder cycle
- s_stb_o  out  1  to decoder strobe
- s_ack_i  in  1  from decoder acknowledge
- gnt_o  out  2  one-hot current grant; 00 = idle

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE, gnt_o 00, last-winner register = 1 (so master 0 wins the first contention), timeout counter 0.
  - All s_* control outputs and all m*_ack_o / m*_err_o are 0 immediately, including mid-cycle. A master sees its transaction dropped without ack.
- FSM states IDLE, GNT0, GNT1, all registered.
- IDLE:
  - only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1.
  - both high -> grant the master that is not the last winner; last winner updated on the grant.
  - neither -> stay.
- Latency: request seen at edge N sets grant at edge N+1; s_cyc_o/s_stb_o assert in cycle N+1 (combinational from grant). Minimum arbitration latency is 1 cycle.
- GNTx:
  - s_adr_o, s_dat_o, s_we_o, s_stb_o follow master x combinationally.
  - s_cyc_o = mx_cyc_i.
  - mx_ack_o = s_ack_i & mx_stb_i; mx_dat_o = s_dat_i.
  - The other master gets ack 0, err 0, dat_o 0.
  - Stay while mx_cyc_i is high; multiple strobes and bursts are allowed within one grant.
  - When mx_cyc_i drops -> IDLE. This gives one mandatory idle bus cycle between grants, even when the other master is waiting; there is no back-to-back handover.
- In IDLE: s_* controls are 0; s_adr_o and s_dat_o are 0.
- Decoder default region acks in the same cycle; the arbiter passes that through unchanged.
- A master dropping cyc_i in the same cycle as ack: ack is still delivered that cycle, then -> IDLE.
- Simultaneous new requests while another grant is active are ignored until IDLE; no preemption.
- Registered outputs: gnt_o only; everything else is combinational from grant plus inputs.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Enabled:
  - 16-bit counter increments each cycle s_stb_o & ~s_ack_i in GNTx; clears on ack, in IDLE, or when stb is low.
  - When the counter reaches TIMEOUT_CYCLES: mx_err_o pulses high for 1 cycle, s_cyc_o/s_stb_o are forced 0 that same cycle, FSM -> IDLE, and last-winner is set to x.
  - A late s_ack_i after the error is discarded.
- Disabled: no counter; m0_err_o and m1_err_o tied 0; a stalled slave holds the bus indefinitely.

Decomposition:
- Shared package wb_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_GNT0=2'd1, ST_GNT1=2'd2;
  - grant encodings GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10.
- One natural sub-module: wb_arb_rr_pick. Combinational: inputs req[1:0] and last; output one-hot pick. Reused if the arbiter grows to more masters.
- Timeout counter stays inline under the macro.

Test Plan:
- Single master: m0 read, cyc/stb at cycle 0, adr 0x05, decoder acks at cycle 2 with 0xA5 -> gnt_o=01 at cycle 1, m0_ack_o=1 and m0_dat_o=0xA5 at cycle 2, m1_ack_o=0 throughout.
- Contention after reset: m0 and m1 both raise cyc at cycle 0 -> m0 granted first. After m0 drops cyc -> one idle cycle (gnt_o=00, s_cyc_o=0), then gnt_o=10.
- Fairness: both masters re-request continuously for 6 transactions -> grants alternate 01,10,01,10,01,10.
- Burst hold: m1 holds cyc through 3 strobes to adr 0x20..0x22 while m0 requests -> m0 is not granted until 1 cycle after m1 cyc falls.
- Async reset mid-cycle: rst_n low during GNT0 with stb high -> s_cyc_o, s_stb_o, m0_ack_o = 0 before the next clk edge; after release, gnt_o=00.
- WB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4: slave never acks -> m0_err_o single-cycle pulse after 4 stalled cycles, s_cyc_o=0, FSM IDLE; without the macro, m0_err_o stays 0.
